// File: rtl/led_chain_tx_if.sv
// Parallel word stream from the frame-buffer reader into led_chain_tx.
// One word per driver device, transferred on in_valid && in_ready.
interface led_chain_tx_if #(
    parameter int unsigned WORD_W = 16
);
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_sof;
    logic              in_ready;

    modport master (output in_data, in_valid, in_sof, input in_ready);
    modport slave  (input in_data, in_valid, in_sof, output in_ready);
endinterface

// File: rtl/led_chain_tx.sv
// LED-panel daisy-chain transmitter: serialises one word per device MSB-first on
// SDI/SCLK, then pulses LE and advances the device index that mirrors the panel.
module led_chain_tx #(
    parameter int unsigned NUMBER_OF_DEVICES = 4,
    parameter int unsigned WORD_W            = 16,
    parameter int unsigned CLK_DIV           = 2
) (
    input  logic            clk,
    input  logic            rst,
    led_chain_tx_if.slave   in_if,
    output logic            sdi,
    output logic            sclk,
    output logic            le,
    output logic [4:0]      dev_idx,
    output logic            frame_done,
    output logic            busy,
    output logic            sof_err
);
    localparam int unsigned PH_W      = $clog2(2 * CLK_DIV);
    localparam int unsigned BC_W      = $clog2(WORD_W);
    localparam int unsigned LAST_DEV  = NUMBER_OF_DEVICES - 1;
    localparam logic [PH_W-1:0] PH_LO_END = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0] PH_HI_END = PH_W'(2 * CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [PH_W-1:0]   phase, phase_nxt;
    logic [BC_W-1:0]   bit_cnt, bit_cnt_nxt;
    logic [WORD_W-1:0] shreg, shreg_nxt;
    logic [4:0]        dev_idx_nxt;
    logic              frame_done_nxt;
    logic              sof_err_nxt;
    logic              sdi_nxt;
    logic              sclk_nxt;
    logic              le_nxt;
    logic              busy_nxt;

    // Only combinational output: accept is possible in IDLE outside reset.
    assign in_if.in_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            dev_idx    <= '0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
            sdi        <= 1'b0;
            sclk       <= 1'b0;
            le         <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            phase      <= phase_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shreg      <= shreg_nxt;
            dev_idx    <= dev_idx_nxt;
            frame_done <= frame_done_nxt;
            sof_err    <= sof_err_nxt;
            sdi        <= sdi_nxt;
            sclk       <= sclk_nxt;
            le         <= le_nxt;
            busy       <= busy_nxt;
        end
    end

    // Next state; pin outputs are decoded from the next state so they register
    // in step with the state they belong to.
    always_comb begin
        state_nxt      = state;
        phase_nxt      = phase;
        bit_cnt_nxt    = bit_cnt;
        shreg_nxt      = shreg;
        dev_idx_nxt    = dev_idx;
        frame_done_nxt = 1'b0;
        sof_err_nxt    = sof_err;

        unique case (state)
            IDLE: begin
                if (in_if.in_valid) begin
                    shreg_nxt   = in_if.in_data;
                    bit_cnt_nxt = BC_W'(WORD_W - 1);
                    phase_nxt   = '0;
                    state_nxt   = SHIFT_LO;
                    if (in_if.in_sof && (dev_idx != 5'd0)) begin
                        sof_err_nxt = 1'b1;
                    end
                end
            end
            SHIFT_LO: begin
                phase_nxt = phase + PH_W'(1);
                if (phase == PH_LO_END) begin
                    state_nxt = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (phase == PH_HI_END) begin
                    phase_nxt = '0;
                    if (bit_cnt == '0) begin
                        state_nxt = LATCH;
                    end else begin
                        shreg_nxt   = shreg << 1;
                        bit_cnt_nxt = bit_cnt - BC_W'(1);
                        state_nxt   = SHIFT_LO;
                    end
                end else begin
                    phase_nxt = phase + PH_W'(1);
                end
            end
            LATCH: begin
                if (phase == PH_HI_END) begin
                    phase_nxt = '0;
                    state_nxt = IDLE;
                    if (dev_idx == 5'(LAST_DEV)) begin
                        dev_idx_nxt    = 5'd0;
                        frame_done_nxt = 1'b1;
                    end else begin
                        dev_idx_nxt = dev_idx + 5'd1;
                    end
                end else begin
                    phase_nxt = phase + PH_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        sclk_nxt = (state_nxt == SHIFT_HI);
        le_nxt   = (state_nxt == LATCH);
        busy_nxt = (state_nxt != IDLE);
        sdi_nxt  = ((state_nxt == SHIFT_LO) || (state_nxt == SHIFT_HI)) ? shreg_nxt[WORD_W-1] : 1'b0;
    end
endmodule

// File: doc/led_chain_tx.md
# led_chain_tx

Transmit side of the LED-panel daisy-chain interface. It accepts one parallel data word per driver device over a valid/ready handshake and serialises it MSB-first on SDI/SCLK. It then pulses LE and advances a 5-bit device index that wraps at NUMBER_OF_DEVICES, mirroring the LE counter held on the panel side. It sits between the frame-buffer reader and the panel's SDI/SCLK/LE pins.

## Interface
- NUMBER_OF_DEVICES, 4, drivers in the chain; legal range 1..32.
- WORD_W, 16, bits per device word; legal range 2..32.
- CLK_DIV, 2, clk cycles per SCLK half-period; legal range ≥1.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- in_data  in  WORD_W  word for device dev_idx.
- in_valid  in  1  in_data valid.
- in_sof  in  1  start-of-frame marker, qualified by in_valid.
- in_ready  out  1  block can accept a word.
- sdi  out  1  serial data to chain.
- sclk  out  1  shift clock to chain.
- le  out  1  latch enable to chain.
- dev_idx  out  5  index of device the next word addresses.
- frame_done  out  1  one-clk pulse after the last device's LE.
- busy  out  1  high in any state other than IDLE.
- sof_err  out  1  sticky; set when in_sof=1 is accepted while dev_idx≠0.

## Operation
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH. A single phase counter (0..2*CLK_DIV-1) and a bit counter (0..WORD_W-1) time all phases.
- IDLE: in_ready=1, sclk=0, le=0.
  - On in_valid&&in_ready: load the shift register with in_data, set bit_cnt=WORD_W-1, go to SHIFT_LO.
  - Check sof: if in_sof=1 and dev_idx≠0, set sof_err. The word is still sent.
- SHIFT_LO: sdi = shift-register MSB, sclk=0, for CLK_DIV cycles, then go to SHIFT_HI.
- SHIFT_HI: sclk=1 and sdi held, for CLK_DIV cycles.
  - At the end, if bit_cnt=0, go to LATCH.
  - Otherwise shift left by one, decrement bit_cnt, and go to SHIFT_LO.
  - sdi changes only while sclk=0.
- LATCH: le=1, sclk=0, sdi=0, for 2*CLK_DIV cycles. On exit go to IDLE and update dev_idx:
  - If dev_idx=NUMBER_OF_DEVICES-1: dev_idx←0 and frame_done pulses for the first IDLE cycle.
  - Otherwise dev_idx←dev_idx+1.
- With NUMBER_OF_DEVICES=1, dev_idx stays 0 and frame_done pulses after every word.
- in_data, in_sof and in_valid are ignored outside IDLE.

## Timing
- All outputs are registered except in_ready = (state==IDLE)&&!rst.
- Reset values: sdi=0, sclk=0, le=0, dev_idx=0, frame_done=0, busy=0, sof_err=0, state IDLE.
- Reset mid-word: the partial word is discarded. No LE is issued and dev_idx returns to 0 on the next edge.
- Accept edge to first SHIFT_LO cycle: 1 clk. sdi shows the MSB in that cycle.
- Word duration from the accept edge to re-entering IDLE: (WORD_W+1)*2*CLK_DIV clk. Defaults give 68 clk.
- Back-to-back words with in_valid held high: one word per (WORD_W+1)*2*CLK_DIV+1 clk (69 at defaults), because of the single IDLE accept cycle.
- SCLK rising edges per word: exactly WORD_W. LE high cycles: exactly 2*CLK_DIV.
- dev_idx and frame_done update on the same edge (LATCH→IDLE).

## Test plan
- Reset, then send 16'hA5C3 at dev_idx 0 with defaults. Required response:
  - sdi sampled at 16 sclk rises reads 1010010111000011.
  - le is high for 4 clk.
  - dev_idx=1 and in_ready=1 at clk 68 after acceptance.
- Send 4 words back-to-back with in_valid held high. Required response:
  - Accepts occur at 69-clk spacing.
  - dev_idx reads 1,2,3,0.
  - frame_done pulses exactly once, together with the 0.
- Set NUMBER_OF_DEVICES=1, WORD_W=8, CLK_DIV=1 and send 3 words. Required response:
  - Each word lasts 18 clk.
  - dev_idx stays 0.
  - frame_done pulses 3 times.
- Accept a word with in_sof=1 at dev_idx=2. Required response:
  - sof_err=1 and stays set.
  - The word is still shifted.
  - dev_idx→3.
  - Only rst clears sof_err.
- Assert rst for 1 clk mid-SHIFT_HI of bit 7. Required response:
  - On the next edge: sclk=0, le=0, busy=0, dev_idx=0.
  - No le pulse occurs for that word.
  - in_ready=1 one cycle after rst drops.
- Toggle in_valid and in_data during SHIFT and LATCH states. Required response: the serial stream is unchanged and no extra accept occurs.
